noekeon_seq: RTL and testbench

Iterative, clocked Noekeon engine (direct-key mode, 128-bit block and key, 16 rounds). It reuses the team's round primitives (theta, pi1, gamma, pi2) for one round per cycle, replacing the fully unrolled combinational loop when area matters. The block owns the round-constant sequencer, the key-preparation step for decryption, and a valid/ready handshake on both sides. It sits between the block-cipher mode logic (ECB/CBC wrapper) and the bus interface.

---
 rtl/noekeon_seq.sv | 192 +++++++++++++++++++
 tb/tb_noekeon_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noekeon_seq.sv
`default_nettype none
// ============================================================================
// Module   : noekeon_seq
// Purpose  : Iterative Noekeon (direct-key, 128/128, 16 rounds), one round per
//            clock, valid/ready on both sides. NOEKEON_SEQ_ABORT_EN adds abort.
// Revision : 1.0
// ============================================================================
module noekeon_seq #(
    parameter int KEY_SIZE   = 128,
    parameter int BLOCK_SIZE = 128,
    parameter int NROUND     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [BLOCK_SIZE-1:0] plaintext,
    input  logic [KEY_SIZE-1:0]   key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] ciphertext,
    output logic                  busy
`ifdef NOEKEON_SEQ_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    localparam int CNT_W = $clog2(NROUND + 1);
    localparam logic [CNT_W-1:0] c_last_round = CNT_W'(NROUND - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEYPREP = 3'd1,
        S_ROUND   = 3'd2,
        S_FINAL   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [127:0]          r_a;
    logic [127:0]          r_k;
    logic [127:0]          r_ct;
    logic [7:0]            r_rc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mode;
    logic                  w_abort;
    logic [127:0]          w_round;
    logic [127:0]          w_final;

`ifdef NOEKEON_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Internal word i lives at bits [32i+31:32i]; the port order is word-reversed.
    function automatic logic [127:0] swap_words(input logic [127:0] x);
        return {x[31:0], x[63:32], x[95:64], x[127:96]};
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] t);
        return t ^ {t[7:0], t[31:8]} ^ {t[23:0], t[31:24]};
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] k, input logic [127:0] a);
        logic [31:0] a0, a1, a2, a3, t;
        {a3, a2, a1, a0} = a;
        t  = mix(a0 ^ a2);
        a1 = a1 ^ t;
        a3 = a3 ^ t;
        a0 = a0 ^ k[31:0];
        a1 = a1 ^ k[63:32];
        a2 = a2 ^ k[95:64];
        a3 = a3 ^ k[127:96];
        t  = mix(a1 ^ a3);
        a0 = a0 ^ t;
        a2 = a2 ^ t;
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] a);
        logic [31:0] a0, a1, a2, a3, t;
        {a3, a2, a1, a0} = a;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] pi1(input logic [127:0] a);
        return {a[125:96], a[127:126], a[90:64], a[95:91], a[62:32], a[63], a[31:0]};
    endfunction

    function automatic logic [127:0] pi2(input logic [127:0] a);
        return {a[97:96], a[127:98], a[68:64], a[95:69], a[32], a[63:33], a[31:0]};
    endfunction

    function automatic logic [127:0] noekeon_round(input logic [127:0] k, input logic [127:0] a,
                                                   input logic [7:0] rc1, input logic [7:0] rc2);
        logic [127:0] s;
        s = theta(k, a ^ {120'd0, rc1});
        s = s ^ {120'd0, rc2};
        return pi2(gamma(pi1(s)));
    endfunction

    function automatic logic [7:0] rc_fwd(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] rc_bwd(input logic [7:0] rc);
        return rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
    endfunction

    assign w_round = r_mode ? noekeon_round(r_k, r_a, 8'h00, r_rc)
                            : noekeon_round(r_k, r_a, r_rc, 8'h00);
    assign w_final = r_mode ? (theta(r_k, r_a) ^ {120'd0, r_rc})
                            : theta(r_k, r_a ^ {120'd0, r_rc});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (in_valid) w_next_state = mode ? S_KEYPREP : S_ROUND;
            S_KEYPREP: w_next_state = S_ROUND;
            S_ROUND:   if (r_cnt == c_last_round) w_next_state = S_FINAL;
            S_FINAL:   w_next_state = S_DONE;
            S_DONE:    if (out_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
        // Abort outranks every other transition, including out_ready in DONE.
        if (w_abort && (r_state != S_IDLE)) w_next_state = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_k    <= '0;
            r_ct   <= '0;
            r_rc   <= 8'h80;
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_abort && (r_state != S_IDLE)) begin
            r_rc  <= 8'h80;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mode <= mode;
                        r_a    <= swap_words(plaintext);
                        r_k    <= swap_words(key);
                        r_rc   <= mode ? 8'hD4 : 8'h80;
                        r_cnt  <= '0;
                    end
                end
                S_KEYPREP: r_k <= theta(128'd0, r_k);
                S_ROUND: begin
                    r_a   <= w_round;
                    r_rc  <= r_mode ? rc_bwd(r_rc) : rc_fwd(r_rc);
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FINAL: begin
                    r_a  <= w_final;
                    r_ct <= swap_words(w_final);
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign ciphertext = r_ct;

endmodule
`default_nettype wire

// File: tb/tb_noekeon_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_noekeon_seq
// Purpose  : Randomised bench for noekeon_seq against a word-array Noekeon model.
// Revision : 1.0
// ============================================================================
module tb_noekeon_seq;

    typedef logic [3:0][31:0] st_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
`ifdef NOEKEON_SEQ_ABORT_EN
    logic         abort;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] c_zero_ct = 128'hb1656851_699e29fa_24b70148_503d2dfc;
    logic [7:0] rc_tbl [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                                8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

    noekeon_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
`ifdef NOEKEON_SEQ_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: words a[0..3], a[0] = most significant port word
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[63-n -: 32];
    endfunction

    function automatic st_t to_words(input logic [127:0] x);
        st_t s;
        for (int i = 0; i < 4; i++) s[i] = x[127-32*i -: 32];
        return s;
    endfunction

    function automatic logic [127:0] from_words(input st_t s);
        logic [127:0] x;
        for (int i = 0; i < 4; i++) x[127-32*i -: 32] = s[i];
        return x;
    endfunction

    function automatic st_t m_theta(input st_t k, input st_t a);
        logic [31:0] t;
        t = a[0] ^ a[2];
        t = t ^ rol(t, 8) ^ rol(t, 24);
        a[1] ^= t;
        a[3] ^= t;
        for (int i = 0; i < 4; i++) a[i] ^= k[i];
        t = a[1] ^ a[3];
        t = t ^ rol(t, 8) ^ rol(t, 24);
        a[0] ^= t;
        a[2] ^= t;
        return a;
    endfunction

    function automatic st_t m_round(input st_t k, input st_t a, input logic [7:0] rc1, input logic [7:0] rc2);
        int          sh [4] = '{0, 1, 5, 2};
        logic [31:0] t;
        a[0] ^= {24'd0, rc1};
        a = m_theta(k, a);
        a[0] ^= {24'd0, rc2};
        for (int i = 1; i < 4; i++) a[i] = rol(a[i], sh[i]);
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        t = a[3]; a[3] = a[0]; a[0] = t;
        a[2] ^= a[0] ^ a[1] ^ a[3];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        for (int i = 1; i < 4; i++) a[i] = rol(a[i], 32 - sh[i]);
        return a;
    endfunction

    function automatic logic [127:0] model(input logic m, input logic [127:0] k_in, input logic [127:0] d_in);
        st_t k, s;
        k = to_words(k_in);
        s = to_words(d_in);
        if (!m) begin
            for (int r = 0; r < 16; r++) s = m_round(k, s, rc_tbl[r], 8'h00);
            s[0] ^= {24'd0, rc_tbl[16]};
            s = m_theta(k, s);
        end else begin
            k = m_theta(st_t'(128'd0), k);
            for (int r = 16; r >= 1; r--) s = m_round(k, s, 8'h00, rc_tbl[r]);
            s = m_theta(k, s);
            s[0] ^= {24'd0, rc_tbl[0]};
        end
        return from_words(s);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Submit one request, check latency, hold the result for `stall` cycles, release it.
    task automatic run_op(input logic m, input logic [127:0] k, input logic [127:0] p,
                          input int stall, input bit early_ready, output logic [127:0] res);
        int           cyc;
        logic [127:0] held;
        check("in_ready_idle", 128'(in_ready), 128'd1);
        mode      = m;
        key       = k;
        plaintext = p;
        in_valid  = 1'b1;
        out_ready = early_ready;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        mode      = ~m;
        key       = rnd128();
        plaintext = rnd128();
        check("busy_after_accept", 128'(busy), 128'd1);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(m ? "dec_latency" : "enc_latency", 128'(cyc), m ? 128'd18 : 128'd17);
        res  = ciphertext;
        held = ciphertext;
        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            @(posedge clk); #1;
            check("hold_valid", 128'(out_valid), 128'd1);
            check("hold_data", ciphertext, held);
            check("hold_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 128'(out_valid), 128'd0);
        check("release_in_ready", 128'(in_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] k, p, c, d;
        int           st;
        bit           er;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        key       = '0;
        plaintext = '0;
`ifdef NOEKEON_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ct", ciphertext, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(1'b0, 128'd0, 128'd0, 0, 1'b0, c);
        check("zero_enc", c, c_zero_ct);
        run_op(1'b1, 128'd0, c, 0, 1'b1, d);
        check("zero_dec", d, 128'd0);

        // Long backpressure with in_valid pulses that must be ignored.
        k = rnd128();
        p = rnd128();
        run_op(1'b0, k, p, 50, 1'b0, c);
        check("bp_result", c, model(1'b0, k, p));
        check("bp_idle_after", 128'(busy), 128'd0);

        // Reset while round 7 is in progress.
        k = rnd128();
        p = rnd128();
        mode = 1'b0; key = k; plaintext = p; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_ct", ciphertext, 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        run_op(1'b0, k, p, 2, 1'b0, c);
        check("postrst_enc", c, model(1'b0, k, p));

`ifdef NOEKEON_SEQ_ABORT_EN
        begin
            logic [127:0] last_ct;
            bit           seen;
            last_ct = c;
            seen    = 1'b0;
            k = rnd128();
            p = rnd128();
            mode = 1'b0; key = k; plaintext = p; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check("abort_in_ready", 128'(in_ready), 128'd1);
            check("abort_busy", 128'(busy), 128'd0);
            check("abort_ct_kept", ciphertext, last_ct);
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1'b1;
            end
            check("abort_no_valid", 128'(seen), 128'd0);
            run_op(1'b1, k, model(1'b0, k, p), 0, 1'b0, d);
            check("abort_then_dec", d, p);
        end
`endif

        for (int i = 0; i < 1000; i++) begin
            k  = rnd128();
            p  = rnd128();
            er = 1'($urandom_range(0, 1));
            st = er ? 0 : int'($urandom_range(0, 3));
            run_op(1'b0, k, p, st, er, c);
            check("rt_enc", c, model(1'b0, k, p));
            er = 1'($urandom_range(0, 1));
            st = er ? 0 : int'($urandom_range(0, 3));
            run_op(1'b1, k, c, st, er, d);
            check("rt_dec", d, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
